// File: rtl/mem_io_pkg.sv
// Shared types and constants for the memory/I-O responder.
package mem_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  // Word offsets of the I/O registers from IO_BASE.
  localparam int unsigned IO_IN_OFS   = 0;
  localparam int unsigned IO_OUT_OFS  = 1;
  localparam int unsigned IO_STAT_OFS = 2;

  // Status register layout.
  localparam int unsigned STAT_DROP_BIT = 0;
  localparam int unsigned STAT_WAIT_LSB = 1;
  localparam int unsigned STAT_WAIT_W   = 4;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM, one-cycle read latency, write-first.
module sp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Access port: a write also presents the new word on rdata.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: one outstanding request, programmable wait
// states, word RAM plus three memory-mapped I/O registers.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       RAM_AW      = 10,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_BASE     = 16'hFFF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              resp_done,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              bad_addr,
  output logic              drop_err,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  output logic              io_out_strobe
);

  localparam logic [ADDR_W-1:0] IO_IN_ADDR   = IO_BASE + ADDR_W'(IO_IN_OFS);
  localparam logic [ADDR_W-1:0] IO_OUT_ADDR  = IO_BASE + ADDR_W'(IO_OUT_OFS);
  localparam logic [ADDR_W-1:0] IO_STAT_ADDR = IO_BASE + ADDR_W'(IO_STAT_OFS);
  localparam logic [3:0]        CNT_INIT     = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;

  state_t state, state_nx;
  logic [3:0]        cnt;
  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              src_ram;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] status;
  logic              accept;
  logic              ram_hit, io_in_hit, io_out_hit, stat_hit, mapped;

  assign accept = (state == IDLE) && req_valid;

  // Address decode of the latched request.
  always_comb begin
    ram_hit    = (req_addr_q[ADDR_W-1:RAM_AW] == '0);
    io_in_hit  = (req_addr_q == IO_IN_ADDR);
    io_out_hit = (req_addr_q == IO_OUT_ADDR);
    stat_hit   = (req_addr_q == IO_STAT_ADDR);
    mapped     = ram_hit || io_in_hit || io_out_hit || stat_hit;
  end

  // Status word: drop flag plus the configured wait-state count.
  always_comb begin
    status = '0;
    status[STAT_DROP_BIT] = drop_err;
    status[STAT_WAIT_LSB +: STAT_WAIT_W] = STAT_WAIT_W'(WAIT_CYCLES);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and response strobes.
  always_comb begin
    state_nx      = state;
    busy          = 1'b1;
    resp_done     = 1'b0;
    bad_addr      = 1'b0;
    io_out_strobe = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req_valid) state_nx = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
      end
      WAIT:   if (cnt == '0) state_nx = ACCESS;
      ACCESS: state_nx = RESP;
      RESP: begin
        resp_done     = 1'b1;
        bad_addr      = !mapped;
        io_out_strobe = req_write_q && io_out_hit;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept, counts down to zero without wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept && (WAIT_CYCLES > 0)) begin
      cnt <= CNT_INIT;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Request capture; held for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if (accept) begin
      req_write_q <= req_write;
      req_addr_q  <= req_addr;
      req_wdata_q <= req_wdata;
    end
  end

  // Sticky flag for requests arriving while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  drop_err <= 1'b0;
    else if (req_valid && busy) drop_err <= 1'b1;
  end

  // I/O register updates and non-RAM read data, all at the ACCESS edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_out  <= '0;
      rdata_q <= '0;
      src_ram <= 1'b0;
    end else if (state == ACCESS) begin
      if (req_write_q) begin
        if (io_out_hit) io_out <= req_wdata_q;
        rdata_q <= '0;
        src_ram <= 1'b0;
      end else begin
        src_ram <= ram_hit;
        if (io_in_hit)       rdata_q <= io_in;
        else if (io_out_hit) rdata_q <= io_out;
        else if (stat_hit)   rdata_q <= status;
        else                 rdata_q <= '0;
      end
    end
  end

  // RAM loads are served straight from the RAM output register, which
  // only changes on the next RAM access, so the value holds between responses.
  assign resp_rdata = src_ram ? ram_rdata : rdata_q;

  sp_ram #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    ((state == ACCESS) && ram_hit),
    .we    (req_write_q),
    .addr  (req_addr_q[RAM_AW-1:0]),
    .wdata (req_wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) checked
// against a behavioural memory/I-O model.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_write [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic [15:0] io_in     [2];
  logic        busy [2], resp_done [2], bad_addr [2], drop_err [2], io_out_strobe [2];
  logic [15:0] resp_rdata [2], io_out [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [15:0] mref [2][1024];
  bit          mval [2][1024];
  logic [15:0] io_out_m [2];
  bit          drop_m [2];
  int          wcyc [2] = '{2, 0};

  always #5 clk = ~clk;

  mem_io_responder #(.WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .busy(busy[0]),
    .resp_done(resp_done[0]), .resp_rdata(resp_rdata[0]), .bad_addr(bad_addr[0]),
    .drop_err(drop_err[0]), .io_in(io_in[0]), .io_out(io_out[0]),
    .io_out_strobe(io_out_strobe[0]));

  mem_io_responder #(.WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .busy(busy[1]),
    .resp_done(resp_done[1]), .resp_rdata(resp_rdata[1]), .bad_addr(bad_addr[1]),
    .drop_err(drop_err[1]), .io_in(io_in[1]), .io_out(io_out[1]),
    .io_out_strobe(io_out_strobe[1]));

  function automatic void exp_access(input int d, input logic [15:0] a,
                                     output logic [15:0] v, output bit bad);
    v = '0; bad = 1'b0;
    if (a < 16'd1024)       v = mref[d][a[9:0]];
    else if (a == 16'hFFF0) v = io_in[d];
    else if (a == 16'hFFF1) v = io_out_m[d];
    else if (a == 16'hFFF2) v = 16'(wcyc[d] * 2 + (drop_m[d] ? 1 : 0));
    else                    bad = 1'b1;
  endfunction

  function automatic void model_store(input int d, input logic [15:0] a, input logic [15:0] wd);
    if (a < 16'd1024) begin
      mref[d][a[9:0]] = wd;
      mval[d][a[9:0]] = 1'b1;
    end else if (a == 16'hFFF1) begin
      io_out_m[d] = wd;
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      io_out_m[d] = '0;
      drop_m[d]   = 1'b0;
    end
  endfunction

  // One transaction on responder d; lat counts edges from the accept edge (=1).
  task automatic txn(input int d, input bit we, input logic [15:0] a, input logic [15:0] wd,
                     input bit poke, output logic [15:0] rd, output bit bad,
                     output int st, output int lat);
    lat = -1; st = 0; rd = '0; bad = 1'b0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = we; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = poke;
    req_write[d] = 1'($urandom); req_addr[d] = 16'($urandom); req_wdata[d] = 16'($urandom);
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      if (io_out_strobe[d]) st++;
      if (resp_done[d]) begin
        lat = k; rd = resp_rdata[d]; bad = bad_addr[d];
        break;
      end
    end
    @(posedge clk); #1;
    if (io_out_strobe[d]) st++;
  endtask

  task automatic test_reset();
    int seen;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_write[d] = 0; req_addr[d] = '0; req_wdata[d] = '0; io_in[d] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({busy[d], resp_done[d], bad_addr[d], drop_err[d], io_out_strobe[d],
           resp_rdata[d], io_out[d]} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got busy=%b done=%b bad=%b drop=%b stb=%b rdata=%h io_out=%h, expected all 0",
                 d, busy[d], resp_done[d], bad_addr[d], drop_err[d], io_out_strobe[d],
                 resp_rdata[d], io_out[d]);
      end
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (resp_done[0] || resp_done[1] || busy[0] || busy[1]) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet: got %0d active cycles, expected 0", seen);
    end
  endtask

  task automatic test_ram();
    logic [15:0] rd; bit bad; int st, lat;
    txn(0, 1, 16'd5, 16'h1234, 0, rd, bad, st, lat);
    model_store(0, 16'd5, 16'h1234);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL store_latency: got %0d expected 4", lat); end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL store_bad: got %b expected 0", bad); end
    txn(0, 0, 16'd5, 16'h0000, 0, rd, bad, st, lat);
    n_checks++;
    if (rd !== 16'h1234 || bad !== 1'b0 || lat !== 4) begin
      n_fail++;
      $display("FAIL load_after_store: got rd=%h bad=%b lat=%0d expected rd=1234 bad=0 lat=4", rd, bad, lat);
    end
    txn(0, 1, 16'd1023, 16'hC0DE, 0, rd, bad, st, lat);
    model_store(0, 16'd1023, 16'hC0DE);
    txn(0, 0, 16'd1023, 16'h0000, 0, rd, bad, st, lat);
    n_checks++;
    if (rd !== 16'hC0DE || bad !== 1'b0) begin
      n_fail++;
      $display("FAIL ram_top_word: got rd=%h bad=%b expected rd=c0de bad=0", rd, bad);
    end
  endtask

  task automatic test_io();
    logic [15:0] rd; bit bad; int st, lat;
    io_in[0] = 16'hBEEF;
    txn(0, 0, 16'hFFF0, 16'h0000, 0, rd, bad, st, lat);
    n_checks++;
    if (rd !== 16'hBEEF || bad !== 1'b0) begin
      n_fail++; $display("FAIL io_in_load: got rd=%h bad=%b expected beef 0", rd, bad);
    end
    txn(0, 1, 16'hFFF1, 16'h00A5, 0, rd, bad, st, lat);
    model_store(0, 16'hFFF1, 16'h00A5);
    n_checks++;
    if (st !== 1 || io_out[0] !== 16'h00A5) begin
      n_fail++; $display("FAIL io_out_store: got strobes=%0d io_out=%h expected 1 00a5", st, io_out[0]);
    end
    txn(0, 0, 16'hFFF1, 16'h0000, 0, rd, bad, st, lat);
    n_checks++;
    if (rd !== 16'h00A5 || st !== 0) begin
      n_fail++; $display("FAIL io_out_load: got rd=%h strobes=%0d expected 00a5 0", rd, st);
    end
  endtask

  task automatic test_unmapped();
    logic [15:0] rd; bit bad; int st, lat;
    txn(0, 1, 16'd0, 16'h4242, 0, rd, bad, st, lat);
    model_store(0, 16'd0, 16'h4242);
    txn(0, 0, 16'h8000, 16'h0000, 0, rd, bad, st, lat);
    n_checks++;
    if (rd !== 16'h0000 || bad !== 1'b1 || lat !== 4) begin
      n_fail++; $display("FAIL unmapped_load: got rd=%h bad=%b lat=%0d expected 0000 1 4", rd, bad, lat);
    end
    txn(0, 1, 16'h8000, 16'h7777, 0, rd, bad, st, lat);
    n_checks++;
    if (bad !== 1'b1) begin n_fail++; $display("FAIL unmapped_store: got bad=%b expected 1", bad); end
    txn(0, 0, 16'd0, 16'h0000, 0, rd, bad, st, lat);
    n_checks++;
    if (rd !== 16'h4242 || bad !== 1'b0) begin
      n_fail++; $display("FAIL word0_intact: got rd=%h bad=%b expected 4242 0", rd, bad);
    end
  endtask

  task automatic test_drop();
    logic [15:0] rd; bit bad; int st, lat;
    txn(0, 1, 16'd7, 16'h0777, 1, rd, bad, st, lat);
    model_store(0, 16'd7, 16'h0777);
    drop_m[0] = 1'b1;
    n_checks++;
    if (lat !== 4 || drop_err[0] !== 1'b1) begin
      n_fail++; $display("FAIL drop_first_txn: got lat=%0d drop=%b expected 4 1", lat, drop_err[0]);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (drop_err[0] !== 1'b1 || drop_err[1] !== 1'b0) begin
      n_fail++; $display("FAIL drop_sticky: got %b/%b expected 1/0", drop_err[0], drop_err[1]);
    end
    txn(0, 0, 16'hFFF2, 16'h0000, 0, rd, bad, st, lat);
    n_checks++;
    if (rd !== 16'h0005) begin n_fail++; $display("FAIL status_load: got %h expected 0005", rd); end
    txn(0, 0, 16'd7, 16'h0000, 0, rd, bad, st, lat);
    n_checks++;
    if (rd !== 16'h0777) begin n_fail++; $display("FAIL drop_no_corrupt: got %h expected 0777", rd); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] rd; bit bad; int st, lat, seen;
    for (int d = 0; d < 2; d++) begin
      txn(d, 1, 16'd9, 16'h0001, 0, rd, bad, st, lat);
      model_store(d, 16'd9, 16'h0001);
      @(negedge clk);
      req_valid[d] = 1; req_write[d] = 1; req_addr[d] = 16'd9; req_wdata[d] = 16'h5555;
      @(posedge clk); #1;
      req_valid[d] = 0;
      n_checks++;
      if (busy[d] !== 1'b1) begin n_fail++; $display("FAIL abort_busy[%0d]: got %b expected 1", d, busy[d]); end
      #2 reset = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (busy[d] !== 1'b0 || resp_done[d] !== 1'b0) begin
        n_fail++; $display("FAIL abort_idle[%0d]: got busy=%b done=%b expected 0 0", d, busy[d], resp_done[d]);
      end
      seen = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        if (resp_done[d]) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL abort_no_resp[%0d]: got %0d expected 0", d, seen); end
      txn(d, 0, 16'd9, 16'h0000, 0, rd, bad, st, lat);
      n_checks++;
      if (rd !== 16'h0001 || lat !== wcyc[d] + 2) begin
        n_fail++; $display("FAIL abort_ram_kept[%0d]: got rd=%h lat=%0d expected 0001 %0d", d, rd, lat, wcyc[d] + 2);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] rd, a, wd, ev; bit bad, eb, we; int st, lat, d, r;
    for (int i = 0; i < 60; i++) begin
      d  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      we = 1'($urandom);
      wd = 16'($urandom);
      if (r <= 4)      a = ($urandom_range(0, 7) == 0) ? 16'd1023 : 16'($urandom_range(0, 31));
      else if (r == 5) a = 16'hFFF0;
      else if (r == 6) a = 16'hFFF1;
      else if (r == 7) a = 16'hFFF2;
      else begin
        case ($urandom_range(0, 3))
          0: a = 16'd1024;
          1: a = 16'hFFEF;
          2: a = 16'hFFF3;
          default: a = 16'($urandom_range(1024, 16'hFFEF));
        endcase
      end
      if (a < 16'd1024 && !mval[d][a[9:0]]) we = 1'b1;
      io_in[d] = 16'($urandom);
      exp_access(d, a, ev, eb);
      txn(d, we, a, wd, 0, rd, bad, st, lat);
      if (we) model_store(d, a, wd);
      n_checks++;
      if (lat !== wcyc[d] + 2 || bad !== eb) begin
        n_fail++; $display("FAIL rand_resp[%0d] dut%0d a=%h we=%b: got lat=%0d bad=%b expected %0d %b",
                           i, d, a, we, lat, bad, wcyc[d] + 2, eb);
      end
      n_checks++;
      if (st !== ((we && a == 16'hFFF1) ? 1 : 0) || io_out[d] !== io_out_m[d]) begin
        n_fail++; $display("FAIL rand_io[%0d] dut%0d a=%h we=%b: got strobes=%0d io_out=%h expected io_out=%h",
                           i, d, a, we, st, io_out[d], io_out_m[d]);
      end
      if (!we) begin
        n_checks++;
        if (rd !== ev) begin
          n_fail++; $display("FAIL rand_load[%0d] dut%0d a=%h: got %h expected %h", i, d, a, rd, ev);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_io();
    test_unmapped();
    test_drop();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
